// File: rtl/dnpcie_aurora_reset_pkg.sv
// rtl/dnpcie_aurora_reset_pkg.sv - shared types and constants for the Aurora reset sequencer
// Contents: chan_state_e (per-channel FSM states), POWERON_CYCLES.
package dnpcie_aurora_reset_pkg;

    typedef enum logic [3:0] {
        POWERON      = 4'd0,
        WAIT_REFCLK  = 4'd1,
        WAIT_USERCLK = 4'd2,
        WAIT_LINKUP  = 4'd3,
        READY        = 4'd4,
        RESET_START  = 4'd5,
        GT_WAIT      = 4'd6,
        HP_WAIT      = 4'd7,
        FAILED       = 4'd8
    } chan_state_e;

    localparam int POWERON_CYCLES = 4;

endpackage

// File: rtl/dnpcie_aurora_reset_mc_if.sv
// rtl/dnpcie_aurora_reset_mc_if.sv - control/status bundle between board registers and the reset sequencer
// Signals: refclk_alive_i, userclk_alive_i, channel_up_i, reset_req_i, hotplug_wait_i (to sequencer);
//          gt_reset_o, chan_reset_o, busy_o, failed_o, retry_count_o (from sequencer).
// Modports: master drives the inputs and observes status, slave is the sequencer.
interface dnpcie_aurora_reset_mc_if #(
    parameter int NUM_CH        = 4,
    parameter int HP_WAIT_WIDTH = 16,
    parameter int RETRY_WIDTH   = 2
);
    logic                          refclk_alive_i;
    logic [NUM_CH-1:0]             userclk_alive_i;
    logic [NUM_CH-1:0]             channel_up_i;
    logic [NUM_CH-1:0]             reset_req_i;
    logic [HP_WAIT_WIDTH-1:0]      hotplug_wait_i;
    logic [NUM_CH-1:0]             gt_reset_o;
    logic [NUM_CH-1:0]             chan_reset_o;
    logic [NUM_CH-1:0]             busy_o;
    logic [NUM_CH-1:0]             failed_o;
    logic [NUM_CH*RETRY_WIDTH-1:0] retry_count_o;

    modport master (
        output refclk_alive_i, userclk_alive_i, channel_up_i, reset_req_i, hotplug_wait_i,
        input  gt_reset_o, chan_reset_o, busy_o, failed_o, retry_count_o
    );

    modport slave (
        input  refclk_alive_i, userclk_alive_i, channel_up_i, reset_req_i, hotplug_wait_i,
        output gt_reset_o, chan_reset_o, busy_o, failed_o, retry_count_o
    );
endinterface

// File: rtl/dnpcie_aurora_reset_chan.sv
// rtl/dnpcie_aurora_reset_chan.sv - reset FSM for one Aurora channel
// Inputs: clk, rst_n (async, active low), tick (shared prescaler pulse), refclk_alive, userclk_alive,
//         channel_up (async, synchronised here), reset_req, hotplug_wait.
// Outputs: gt_reset, chan_reset (registered), busy, failed, retry_count.
module dnpcie_aurora_reset_chan
    import dnpcie_aurora_reset_pkg::*;
#(
    parameter int GT_RESET_WAIT  = 162,
    parameter int HP_WAIT_WIDTH  = 16,
    parameter int LINKUP_TIMEOUT = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int RETRY_WIDTH    = 2,
    parameter int AUTO_RECOVER   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic                     refclk_alive,
    input  logic                     userclk_alive,
    input  logic                     channel_up,
    input  logic                     reset_req,
    input  logic [HP_WAIT_WIDTH-1:0] hotplug_wait,
    output logic                     gt_reset,
    output logic                     chan_reset,
    output logic                     busy,
    output logic                     failed,
    output logic [RETRY_WIDTH-1:0]   retry_count
);
    localparam int CYC_MAX = (GT_RESET_WAIT > POWERON_CYCLES) ? GT_RESET_WAIT : POWERON_CYCLES;
    localparam int CW      = $clog2(CYC_MAX + 1);
    localparam int TO_W    = $clog2(LINKUP_TIMEOUT + 1);
    localparam int TW      = (TO_W > HP_WAIT_WIDTH) ? TO_W : HP_WAIT_WIDTH;

    chan_state_e            state_q, state_d;
    logic [CW-1:0]          cyc_q, cyc_d;       // POWERON and GT_WAIT cycle count
    logic [TW-1:0]          tick_q, tick_d;     // WAIT_LINKUP timeout and HP_WAIT tick count
    logic [TW-1:0]          hp_lat_q, hp_lat_d;
    logic [RETRY_WIDTH-1:0] retry_q, retry_d;
    logic                   gt_q, gt_d, chan_q, chan_d;
    logic                   up_meta_q, up_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= POWERON;
            cyc_q     <= '0;
            tick_q    <= '0;
            hp_lat_q  <= '0;
            retry_q   <= '0;
            gt_q      <= 1'b1;
            chan_q    <= 1'b1;
            up_meta_q <= 1'b0;
            up_sync_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            tick_q    <= tick_d;
            hp_lat_q  <= hp_lat_d;
            retry_q   <= retry_d;
            gt_q      <= gt_d;
            chan_q    <= chan_d;
            up_meta_q <= channel_up;
            up_sync_q <= up_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        tick_d   = tick_q;
        hp_lat_d = hp_lat_q;
        retry_d  = retry_q;
        gt_d     = gt_q;
        chan_d   = chan_q;
        case (state_q)
            POWERON: begin
                if (cyc_q == CW'(POWERON_CYCLES - 1)) begin
                    cyc_d   = '0;
                    state_d = WAIT_REFCLK;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            WAIT_REFCLK: begin
                if (refclk_alive) begin
                    gt_d    = 1'b0;
                    state_d = WAIT_USERCLK;
                end
            end
            WAIT_USERCLK: begin
                if (userclk_alive) begin
                    chan_d  = 1'b0;
                    tick_d  = '0;
                    state_d = WAIT_LINKUP;
                end
            end
            WAIT_LINKUP: begin
                // A software request pre-empts both link-up and timeout and is not a retry.
                if (reset_req) begin
                    state_d = RESET_START;
                end else if (up_sync_q) begin
                    retry_d = '0;
                    state_d = READY;
                end else if (tick) begin
                    if (tick_q == TW'(LINKUP_TIMEOUT - 1)) begin
                        if (retry_q == RETRY_WIDTH'(MAX_RETRIES)) begin
                            gt_d    = 1'b1;
                            chan_d  = 1'b1;
                            state_d = FAILED;
                        end else begin
                            retry_d = retry_q + RETRY_WIDTH'(1);
                            state_d = RESET_START;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            READY: begin
                if (reset_req || ((AUTO_RECOVER != 0) && !up_sync_q)) begin
                    state_d = RESET_START;
                end
            end
            RESET_START: begin
                // A zero hotplug wait still waits for one tick.
                hp_lat_d = (hotplug_wait == '0) ? TW'(1) : TW'(hotplug_wait);
                cyc_d    = '0;
                chan_d   = 1'b1;
                state_d  = GT_WAIT;
            end
            GT_WAIT: begin
                if (cyc_q == CW'(GT_RESET_WAIT - 1)) begin
                    gt_d    = 1'b1;
                    tick_d  = '0;
                    state_d = HP_WAIT;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            HP_WAIT: begin
                if (tick) begin
                    if (tick_q == hp_lat_q - TW'(1)) begin
                        gt_d    = 1'b0;
                        state_d = WAIT_USERCLK;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            FAILED: begin
                gt_d   = 1'b1;
                chan_d = 1'b1;
                if (reset_req) begin
                    retry_d = '0;
                    state_d = RESET_START;
                end
            end
            default: begin
                cyc_d   = '0;
                gt_d    = 1'b1;
                chan_d  = 1'b1;
                state_d = POWERON;
            end
        endcase
    end

    assign gt_reset    = gt_q;
    assign chan_reset  = chan_q;
    assign busy        = (state_q != READY);
    assign failed      = (state_q == FAILED);
    assign retry_count = retry_q;

endmodule

// File: rtl/dnpcie_aurora_reset_mc.sv
// rtl/dnpcie_aurora_reset_mc.sv - multi-channel Aurora reset sequencer with shared tick prescaler
// Ports: init_clk, init_rst_n (async, active low), bus (dnpcie_aurora_reset_mc_if.slave).
module dnpcie_aurora_reset_mc
    import dnpcie_aurora_reset_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int GT_RESET_WAIT  = 162,
    parameter int TICK_LOG2      = 16,
    parameter int HP_WAIT_WIDTH  = 16,
    parameter int LINKUP_TIMEOUT = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int RETRY_WIDTH    = 2,
    parameter int AUTO_RECOVER   = 1
) (
    input  logic                     init_clk,
    input  logic                     init_rst_n,
    dnpcie_aurora_reset_mc_if.slave  bus
);
    logic [TICK_LOG2-1:0] presc_q;
    logic                 tick;

    always_ff @(posedge init_clk or negedge init_rst_n) begin
        if (!init_rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + TICK_LOG2'(1);
        end
    end

    assign tick = &presc_q;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
        dnpcie_aurora_reset_chan #(
            .GT_RESET_WAIT  (GT_RESET_WAIT),
            .HP_WAIT_WIDTH  (HP_WAIT_WIDTH),
            .LINKUP_TIMEOUT (LINKUP_TIMEOUT),
            .MAX_RETRIES    (MAX_RETRIES),
            .RETRY_WIDTH    (RETRY_WIDTH),
            .AUTO_RECOVER   (AUTO_RECOVER)
        ) u_chan (
            .clk           (init_clk),
            .rst_n         (init_rst_n),
            .tick          (tick),
            .refclk_alive  (bus.refclk_alive_i),
            .userclk_alive (bus.userclk_alive_i[n]),
            .channel_up    (bus.channel_up_i[n]),
            .reset_req     (bus.reset_req_i[n]),
            .hotplug_wait  (bus.hotplug_wait_i),
            .gt_reset      (bus.gt_reset_o[n]),
            .chan_reset    (bus.chan_reset_o[n]),
            .busy          (bus.busy_o[n]),
            .failed        (bus.failed_o[n]),
            .retry_count   (bus.retry_count_o[n*RETRY_WIDTH +: RETRY_WIDTH])
        );
    end

endmodule

// File: doc/dnpcie_aurora_reset_mc.md
Name: dnpcie_aurora_reset_mc

Overview:
Multi-channel, parametrised successor to the single-link Aurora reset sequencer. It runs one reset FSM per Aurora channel and shares one refclk-alive check, one hotplug prescaler and one hotplug-wait value across all channels. New relative to the single-link sequencer: a link-up timeout with bounded automatic retry, a FAILED state, optional auto-recovery on channel_up loss, and per-channel status. Sits between the board control/status registers and NUM_CH Aurora cores, all in the init_clk domain.

Parameters:
NUM_CH, 4, number of Aurora channels.
GT_RESET_WAIT, 162, init_clk cycles from chan_reset assertion to gt_reset assertion.
TICK_LOG2, 16, hotplug/timeout tick period = 2^TICK_LOG2 init_clk cycles.
HP_WAIT_WIDTH, 16, width of hotplug_wait_i (in ticks).
LINKUP_TIMEOUT, 1024, ticks allowed in WAIT_LINKUP.
MAX_RETRIES, 3, automatic retries before FAILED.
RETRY_WIDTH, 2, width of each retry counter; must hold MAX_RETRIES.
AUTO_RECOVER, 1, if 1, loss of channel_up in READY starts a reset.

Ports:
init_clk  in  1  the single clock.
init_rst_n  in  1  asynchronous, active-low reset.
refclk_alive_i  in  1  GT refclk toggle indicator, already in the init_clk domain.
userclk_alive_i  in  NUM_CH  per-channel user_clk toggle indicators, already in the init_clk domain.
channel_up_i  in  NUM_CH  Aurora channel_up, asynchronous; 2-FF synchronised inside.
reset_req_i  in  NUM_CH  per-channel software reset request, level.
hotplug_wait_i  in  HP_WAIT_WIDTH  hotplug wait in ticks; latched per channel in RESET_START.
gt_reset_o  out  NUM_CH  GT reset, registered.
chan_reset_o  out  NUM_CH  channel reset, registered; the core synchronises it to user_clk.
busy_o  out  NUM_CH  1 whenever the channel state is not READY.
failed_o  out  NUM_CH  1 while the channel is in FAILED.
retry_count_o  out  NUM_CH*RETRY_WIDTH  retries since the last READY, channel n at slice [n*RETRY_WIDTH +: RETRY_WIDTH].

Behaviour:
- While init_rst_n is low: gt_reset_o=all 1, chan_reset_o=all 1, busy_o=all 1, failed_o=0, retry counts 0, all FSMs in POWERON, prescaler cleared.
- Prescaler: free-running; tick is high for one cycle every 2^TICK_LOG2 cycles. Tick-based waits count tick pulses, so the first tick may be partial.
- Per-channel FSM states and transitions:
  - POWERON: stays 4 cycles, then WAIT_REFCLK.
  - WAIT_REFCLK: on refclk_alive_i=1, gt_reset_o falls on the same edge and the state moves to WAIT_USERCLK.
  - WAIT_USERCLK: on userclk_alive_i[n]=1, chan_reset_o falls on the same edge and the state moves to WAIT_LINKUP.
  - WAIT_LINKUP: timeout counter cleared on entry.
    - Synchronised channel_up=1 -> READY; retry count cleared.
    - Timeout reaches LINKUP_TIMEOUT with retries<MAX_RETRIES -> retry count +1, RESET_START.
    - Timeout reached with retries=MAX_RETRIES -> FAILED.
    - reset_req_i[n]=1 -> RESET_START, no retry counted.
  - READY: reset_req_i[n]=1 -> RESET_START. With AUTO_RECOVER=1, synchronised channel_up=0 -> RESET_START. If both occur in the same cycle, a single RESET_START.
  - RESET_START: latch hotplug_wait_i, go to GT_WAIT; chan_reset_o rises on the edge entering GT_WAIT.
  - GT_WAIT: count GT_RESET_WAIT cycles; gt_reset_o rises on the edge entering HP_WAIT.
  - HP_WAIT: count ticks up to the latched value (0 is treated as 1); gt_reset_o falls on the edge entering WAIT_USERCLK.
  - FAILED: gt_reset_o=1, chan_reset_o=1, failed_o=1. Leaves only on reset_req_i[n]=1 -> RESET_START, with retry count cleared and failed_o falling.
- reset_req_i is ignored in POWERON, WAIT_REFCLK, WAIT_USERCLK, RESET_START, GT_WAIT and HP_WAIT.
- Latency: reset_req_i sampled high at edge k -> RESET_START at k+1, chan_reset_o=1 at k+2, gt_reset_o=1 at k+2+GT_RESET_WAIT.
- Channels are independent. Only refclk_alive_i, hotplug_wait_i and the tick are shared.
- The refclk check happens only at power-on; retries never revisit WAIT_REFCLK.
- Illegal state encodings go to POWERON with gt_reset_o and chan_reset_o asserted.

Decomposition:
- Package dnpcie_aurora_reset_pkg holds the state enum (POWERON, WAIT_REFCLK, WAIT_USERCLK, WAIT_LINKUP, READY, RESET_START, GT_WAIT, HP_WAIT, FAILED) and the POWERON_CYCLES=4 constant.
- Sub-module dnpcie_aurora_reset_chan holds one channel: FSM, GT/hotplug/timeout counters, channel_up synchroniser and retry counter.
- The top level holds the prescaler and the generate loop over NUM_CH.

Test Plan:
- Power-on: release reset, refclk_alive_i=1 at cycle 10, userclk_alive_i=all 1 at cycle 20, channel_up at cycle 40 -> gt_reset_o=0 by cycle ~11, chan_reset_o=0 by ~21, busy_o=0 about 3 cycles after channel_up.
- Software reset ch2 (TICK_LOG2=4, hotplug_wait_i=3): pulse reset_req_i[2] -> chan_reset_o[2]=1 after 2 cycles, gt_reset_o[2]=1 after 164 cycles, gt_reset_o[2]=0 after 3 ticks (33..48 cycles); other channels untouched.
- Retry/fail (LINKUP_TIMEOUT=2, MAX_RETRIES=3, channel_up held 0): retry_count_o goes 1,2,3, then failed_o=1; a reset_req_i pulse clears it to 0 and restarts the sequence.
- Auto-recover: drop channel_up_i[0] in READY -> busy_o[0]=1 and chan_reset_o[0]=1 within 5 cycles. With AUTO_RECOVER=0 -> no change.
- Async reset in mid-sequence: assert init_rst_n=0 during GT_WAIT -> all outputs return to reset values immediately, without waiting for a clock edge.
- Boundary: hotplug_wait_i=0 -> HP_WAIT lasts exactly 1 tick. Simultaneous reset_req_i and channel_up loss -> exactly one reset sequence.
